sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares the single 32-bit asynchronous SRAM between the instruction-fetch port and the MEM-stage data port. Grants one requester at a time and sequences the multi-cycle SRAM read or write strobes. Formats byte/half/word loads and stores. Returns a one-cycle success pulse that releases the requester's pipeline stall. Sits between the CPU core (IF stage, MEM stage) and the top-level SRAM pins.

## Interface
Parameters:
- WAIT_CYCLES, 3, number of ACCESS-state cycles per SRAM transaction; minimum 2.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  instruction fetch request; level, held until if_success.
- if_addr  in  32  fetch byte address; word aligned.
- if_data  out  32  fetched word; valid only while if_success=1.
- if_success  out  1  one-cycle completion pulse for the fetch.
- mem_ramOp  in  4  MEM-stage operation, `MEM_NOP` = no request; held until mem_success.
- mem_addr  in  32  data byte address.
- mem_storeData  in  32  store data, right-justified.
- mem_load_data  out  32  formatted load result; valid only while mem_success=1.
- mem_success  out  1  one-cycle completion pulse for the data access.
- mem_misalign  out  1  high together with mem_success when the access was rejected as misaligned.
- sram_addr  out  20  SRAM word address = addr[21:2].
- sram_wdata  out  32  write data lanes.
- sram_rdata  in  32  read data from pins.
- sram_data_oe  out  1  top-level tristate enable for sram_wdata.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low chip enable, output enable and write enable.
- sram_be_n  out  4  active-low byte enables; bit i maps to byte lane [8i+7:8i].

## Operation
- Ops in the shared defines are: MEM_NOP, LB, LBU, LH, LHU, LW, SB, SH, SW. Fetch is always LW.
- FSM states:
  - IDLE → ACCESS when a request is granted.
  - ACCESS lasts WAIT_CYCLES cycles, using a down-counter.
  - ACCESS → DONE.
  - DONE → IDLE unconditionally.
- Arbitration in IDLE:
  - If only one requester is pending, that requester is granted.
  - If both are pending, the requester not granted last wins. This uses a last_grant flag, with reset value = fetch, so data wins the first tie.
- Grant latches the op, address, store data and requester into registers. SRAM outputs are driven only from these registers.
- Misalignment check:
  - LH/LHU/SH with addr[0]=1 is misaligned.
  - LW/SW with addr[1:0]≠0 is misaligned.
  - A misaligned op does not touch the SRAM. It goes IDLE → DONE, and DONE asserts mem_success=1, mem_misalign=1 and mem_load_data=0.
- Reads:
  - ce_n=0, oe_n=0 and be_n=0000 during all ACCESS cycles.
  - sram_rdata is captured on the last ACCESS edge.
- Writes:
  - ce_n=0 and data_oe=1 during ACCESS and DONE.
  - we_n=0 in ACCESS cycles 2..WAIT_CYCLES; we_n=1 in DONE, which provides the hold time.
- Load formatting (little-endian):
  - The byte or halfword is selected by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Store formatting:
  - SB replicates the byte to all 4 lanes, with be_n low only for lane addr[1:0].
  - SH replicates the halfword, with be_n=1100 for addr[1]=0 and 0011 for addr[1]=1.
  - SW uses be_n=0000.
- success goes only to the requester that was granted. The other requester's success stays 0.

## Timing
- Reset values, taking effect on the first edge with rst=1:
  - FSM in IDLE, last_grant=fetch.
  - if_success=0, mem_success=0, mem_misalign=0, if_data=0, mem_load_data=0.
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_be_n=1111, sram_data_oe=0, sram_addr=0, sram_wdata=0.
- Reset mid-transaction aborts the transaction. No success pulse is issued, and strobes are released on that edge.
- Cycle accounting, with the request visible in IDLE at cycle 0:
  - ACCESS occupies cycles 1..WAIT_CYCLES.
  - success is asserted in cycle WAIT_CYCLES+1, which is cycle 4 at the default setting.
  - A misaligned op gets success in cycle 1.
- The cycle after DONE is always IDLE, and no success is asserted in it.
- A requester advancing on the success edge presents its next request in that IDLE cycle, so there is no double issue.
- Back-to-back transactions by one requester are separated by exactly one IDLE cycle.
- A request that changes or drops mid-transaction is ignored; the latched copy completes.

## Structure
- MEM_* op encodings go in the codebase's shared defines header with the existing `MEM_NOP`. FSM state encodings stay local.
- One sub-module, lsu_align, is combinational. It maps (op, addr[1:0], storeData, rdata) to (wdata, be_n, load_data, misalign). It is instantiated once in the datapath.

## Test plan
- LW, mem_addr=0x00000104, SRAM word 0x8899AABB → sram_addr=0x41, mem_success in cycle 4 with mem_load_data=0x8899AABB, if_success stays 0.
- LB, addr=0x107, same word → mem_load_data=0xFFFFFF88. LBU → 0x00000088. LHU, addr=0x106 → 0x00008899.
- SB, addr=0x201, data=0x000000A5 → sram_wdata=0xA5A5A5A5, be_n=1101. we_n low only in cycles 2..3. data_oe=1 through DONE.
- LH, addr=0x103 → success in cycle 1, mem_misalign=1, load_data=0, ce_n stays 1 throughout.
- if_req and LW held together continuously from reset → data granted first, then fetch, then data; two one-cycle IDLE gaps are observed.
- rst asserted in cycle 2 of an SW → strobes released next edge, no success pulse, FSM in IDLE; a subsequent LW completes normally.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: MEM-stage op encodings, grant owner
// and the alignment rule used both at grant time and in the datapath.
package sram_arbiter_pkg;

    localparam logic [3:0] MEM_NOP = 4'd0;
    localparam logic [3:0] MEM_LB  = 4'd1;
    localparam logic [3:0] MEM_LBU = 4'd2;
    localparam logic [3:0] MEM_LH  = 4'd3;
    localparam logic [3:0] MEM_LHU = 4'd4;
    localparam logic [3:0] MEM_LW  = 4'd5;
    localparam logic [3:0] MEM_SB  = 4'd6;
    localparam logic [3:0] MEM_SH  = 4'd7;
    localparam logic [3:0] MEM_SW  = 4'd8;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    function automatic logic is_store(input logic [3:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] addr_lo);
        return (((op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH)) && addr_lo[0]) ||
               (((op == MEM_LW) || (op == MEM_SW)) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of the fetch port, the MEM-stage data port and the SRAM pins.
// The arbiter connects through the slave modport; the core/board side is master.
interface sram_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_success;

    logic [3:0]  mem_ramOp;
    logic [31:0] mem_addr;
    logic [31:0] mem_storeData;
    logic [31:0] mem_load_data;
    logic        mem_success;
    logic        mem_misalign;

    logic [19:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_data_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [3:0]  sram_be_n;

    modport slave (
        input  if_req, if_addr, mem_ramOp, mem_addr, mem_storeData, sram_rdata,
        output if_data, if_success, mem_load_data, mem_success, mem_misalign,
               sram_addr, sram_wdata, sram_data_oe, sram_ce_n, sram_oe_n,
               sram_we_n, sram_be_n
    );

    modport master (
        output if_req, if_addr, mem_ramOp, mem_addr, mem_storeData, sram_rdata,
        input  if_data, if_success, mem_load_data, mem_success, mem_misalign,
               sram_addr, sram_wdata, sram_data_oe, sram_ce_n, sram_oe_n,
               sram_we_n, sram_be_n
    );

endinterface

// File: rtl/sram_arbiter_lsu_align.sv
// Combinational load/store lane formatter: builds write lanes and byte enables
// for stores, and extracts/extends the addressed byte or halfword for loads.
module lsu_align
    import sram_arbiter_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be_n,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        rd_byte   = rdata[{addr_lo, 3'b000} +: 8];
        rd_half   = rdata[{addr_lo[1], 4'b0000} +: 16];
        misalign  = is_misaligned(op, addr_lo);
        load_data = '0;
        wdata     = '0;
        be_n      = 4'b1111;
        case (op)
            MEM_LB:  load_data = {{24{rd_byte[7]}}, rd_byte};
            MEM_LBU: load_data = {24'h0, rd_byte};
            MEM_LH:  load_data = {{16{rd_half[15]}}, rd_half};
            MEM_LHU: load_data = {16'h0, rd_half};
            MEM_LW:  load_data = rdata;
            MEM_SB: begin
                wdata = {4{store_data[7:0]}};
                be_n  = ~(4'b0001 << addr_lo);
            end
            MEM_SH: begin
                wdata = {2{store_data[15:0]}};
                be_n  = addr_lo[1] ? 4'b0011 : 4'b1100;
            end
            MEM_SW: begin
                wdata = store_data;
                be_n  = 4'b0000;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates the shared asynchronous SRAM between instruction fetch and the
// MEM-stage data port, sequencing multi-cycle read/write strobes per grant.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 3
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus
);

    localparam int               CNT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t           state, state_next;
    grant_t           last_grant, grant_q;
    logic [3:0]       op_q;
    logic [31:0]      addr_q, store_q, rdata_q;
    logic [CNT_W-1:0] cnt;
    logic             mem_pend, grant_any, grant_data, grant_misalign;
    logic             is_write, mem_done, if_done;
    logic [31:0]      align_wdata, align_load;
    logic [3:0]       align_be_n;
    logic             align_misalign;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^addr_q[31:22];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Alternating tie-break: the requester not served last wins when both wait.
    always_comb begin
        mem_pend       = (bus.mem_ramOp != MEM_NOP);
        grant_any      = mem_pend || bus.if_req;
        grant_data     = mem_pend && (!bus.if_req || (last_grant == GRANT_FETCH));
        grant_misalign = grant_data && is_misaligned(bus.mem_ramOp, bus.mem_addr[1:0]);
        state_next     = state;
        case (state)
            IDLE:    if (grant_any) state_next = grant_misalign ? DONE : ACCESS;
            ACCESS:  if (cnt == CNT_W'(1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GRANT_FETCH;
            grant_q    <= GRANT_FETCH;
            op_q       <= MEM_NOP;
            addr_q     <= '0;
            store_q    <= '0;
            rdata_q    <= '0;
            cnt        <= '0;
        end else if (state == IDLE && grant_any) begin
            last_grant <= grant_data ? GRANT_DATA : GRANT_FETCH;
            grant_q    <= grant_data ? GRANT_DATA : GRANT_FETCH;
            op_q       <= grant_data ? bus.mem_ramOp : MEM_LW;
            addr_q     <= grant_data ? bus.mem_addr : bus.if_addr;
            store_q    <= bus.mem_storeData;
            cnt        <= CNT_LOAD;
        end else if (state == ACCESS) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) rdata_q <= bus.sram_rdata;
        end
    end

    lsu_align u_align (
        .op         (op_q),
        .addr_lo    (addr_q[1:0]),
        .store_data (store_q),
        .rdata      (rdata_q),
        .wdata      (align_wdata),
        .be_n       (align_be_n),
        .load_data  (align_load),
        .misalign   (align_misalign)
    );

    // Writes keep ce_n/data_oe through DONE with we_n released, giving data hold.
    always_comb begin
        is_write          = is_store(op_q);
        mem_done          = (state == DONE) && (grant_q == GRANT_DATA);
        if_done           = (state == DONE) && (grant_q == GRANT_FETCH);
        bus.sram_addr     = addr_q[21:2];
        bus.sram_wdata    = align_wdata;
        bus.sram_ce_n     = 1'b1;
        bus.sram_oe_n     = 1'b1;
        bus.sram_we_n     = 1'b1;
        bus.sram_be_n     = 4'b1111;
        bus.sram_data_oe  = 1'b0;
        if (state == ACCESS && !is_write) begin
            bus.sram_ce_n = 1'b0;
            bus.sram_oe_n = 1'b0;
            bus.sram_be_n = 4'b0000;
        end
        if ((state == ACCESS || state == DONE) && is_write && !align_misalign) begin
            bus.sram_ce_n    = 1'b0;
            bus.sram_data_oe = 1'b1;
            bus.sram_be_n    = align_be_n;
            if (state == ACCESS && cnt != CNT_LOAD) bus.sram_we_n = 1'b0;
        end
        bus.mem_success   = mem_done;
        bus.mem_misalign  = mem_done && align_misalign;
        bus.mem_load_data = (mem_done && !align_misalign) ? align_load : '0;
        bus.if_success    = if_done;
        bus.if_data       = if_done ? rdata_q : '0;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus randomized
// traffic checked against a word-array reference memory.
module tb_sram_arbiter;
    import sram_arbiter_pkg::*;

    localparam int WAIT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] sram_mem [0:1023];
    logic [31:0] ref_mem  [0:1023];

    sram_arbiter_if bus();

    sram_arbiter #(.WAIT_CYCLES(WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM model: drives data only while selected for read.
    assign bus.sram_rdata = (!bus.sram_ce_n && !bus.sram_oe_n) ? sram_mem[bus.sram_addr[9:0]]
                                                               : 32'hDEADBEEF;

    always @(posedge clk) begin
        if (!bus.sram_ce_n && !bus.sram_we_n)
            for (int i = 0; i < 4; i++)
                if (!bus.sram_be_n[i])
                    sram_mem[bus.sram_addr[9:0]][8*i +: 8] = bus.sram_wdata[8*i +: 8];
    end

    function automatic logic is_load_op(input logic [3:0] op);
        return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
    endfunction

    function automatic logic ref_misalign(input logic [3:0] op, input logic [31:0] addr);
        if (op inside {MEM_LH, MEM_LHU, MEM_SH}) return (addr % 2) != 0;
        if (op inside {MEM_LW, MEM_SW})          return (addr % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] addr);
        int unsigned w, b, h;
        w = ref_mem[addr[11:2]];
        b = (w / (1 << (8 * (addr % 4)))) % 256;
        h = (w / (1 << (16 * ((addr / 2) % 2)))) % 65536;
        case (op)
            MEM_LB:  return 32'((b >= 128) ? b - 256 : b);
            MEM_LBU: return 32'(b);
            MEM_LH:  return 32'((h >= 32768) ? h - 65536 : h);
            MEM_LHU: return 32'(h);
            MEM_LW:  return 32'(w);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [3:0] op, input logic [31:0] data);
        case (op)
            MEM_SB:  return (data % 256) * 32'h01010101;
            MEM_SH:  return (data % 65536) * 32'h00010001;
            default: return data;
        endcase
    endfunction

    function automatic logic [3:0] ref_lanes(input logic [3:0] op, input logic [31:0] addr);
        case (op)
            MEM_SB:  return 4'(1 << (addr % 4));
            MEM_SH:  return ((addr / 2) % 2) ? 4'b1100 : 4'b0011;
            MEM_SW:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic ref_store(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] wd;
        logic [3:0]  ln;
        wd = ref_wdata(op, data);
        ln = ref_lanes(op, addr);
        for (int i = 0; i < 4; i++)
            if (ln[i]) ref_mem[addr[11:2]][8*i +: 8] = wd[8*i +: 8];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.if_req    = 1'b0;
        bus.mem_ramOp = MEM_NOP;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives one data request from an IDLE cycle and records what the pins did.
    task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                           output int lat, output logic [31:0] ld, output logic mis,
                           output logic if_seen, output logic ce_seen, output logic [31:0] we_mask,
                           output logic oe_done, output logic [31:0] wd, output logic [3:0] be,
                           output logic [19:0] sa, output logic gap);
        bus.mem_ramOp = op; bus.mem_addr = addr; bus.mem_storeData = data;
        lat = -1; ld = '0; mis = 1'b0; if_seen = 1'b0; ce_seen = 1'b0; we_mask = '0;
        oe_done = 1'b0; wd = '0; be = 4'hF; sa = '0; gap = 1'b0;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(negedge clk);
            if (!bus.sram_ce_n)  ce_seen = 1'b1;
            if (!bus.sram_we_n)  we_mask[c] = 1'b1;
            if (bus.if_success)  if_seen = 1'b1;
            if (c == 1) sa = bus.sram_addr;
            if (c == 2) begin
                wd = bus.sram_wdata;
                be = bus.sram_be_n;
                bus.mem_addr      = $urandom;
                bus.mem_storeData = $urandom;
            end
            if (bus.mem_success) begin
                lat = c; ld = bus.mem_load_data; mis = bus.mem_misalign;
                oe_done = bus.sram_data_oe;
            end
        end
        bus.mem_ramOp = MEM_NOP;
        @(negedge clk);
        gap = bus.mem_success || bus.if_success;
    endtask

    task automatic run_if(input logic [31:0] addr, output int lat, output logic [31:0] d,
                          output logic mem_seen, output logic gap);
        bus.if_req = 1'b1; bus.if_addr = addr;
        lat = -1; d = '0; mem_seen = 1'b0; gap = 1'b0;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(negedge clk);
            if (bus.mem_success) mem_seen = 1'b1;
            if (bus.if_success) begin lat = c; d = bus.if_data; end
        end
        bus.if_req = 1'b0;
        @(negedge clk);
        gap = bus.if_success || bus.mem_success;
    endtask

    task automatic test_reset();
        logic [9:0] strobes;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        strobes = {bus.if_success, bus.mem_success, bus.mem_misalign, bus.sram_ce_n,
                   bus.sram_oe_n, bus.sram_we_n, bus.sram_be_n};
        checks++; if (strobes !== 10'b000_111_1111) begin errors++;
            $display("FAIL reset_strobes got %b want %b", strobes, 10'b000_111_1111); end
        checks++; if (bus.sram_data_oe !== 1'b0) begin errors++;
            $display("FAIL reset_data_oe got %b want 0", bus.sram_data_oe); end
        checks++; if (bus.sram_addr !== 20'h0) begin errors++;
            $display("FAIL reset_sram_addr got %h want 0", bus.sram_addr); end
        checks++; if (bus.sram_wdata !== 32'h0) begin errors++;
            $display("FAIL reset_sram_wdata got %h want 0", bus.sram_wdata); end
        checks++; if (bus.if_data !== 32'h0 || bus.mem_load_data !== 32'h0) begin errors++;
            $display("FAIL reset_data got if=%h mem=%h want 0", bus.if_data, bus.mem_load_data); end
        rst = 1'b0;
    endtask

    task automatic test_lw();
        int lat; logic [31:0] ld, wm, wd; logic mis, ifs, ce, oe, gap; logic [3:0] be; logic [19:0] sa;
        run_mem(MEM_LW, 32'h104, 32'h0, lat, ld, mis, ifs, ce, wm, oe, wd, be, sa, gap);
        checks++; if (sa !== 20'h41) begin errors++; $display("FAIL lw_sram_addr got %h want 41", sa); end
        checks++; if (lat !== WAIT + 1) begin errors++; $display("FAIL lw_latency got %0d want %0d", lat, WAIT + 1); end
        checks++; if (ld !== 32'h8899AABB) begin errors++; $display("FAIL lw_data got %h want 8899aabb", ld); end
        checks++; if (ifs !== 1'b0) begin errors++; $display("FAIL lw_if_success got %b want 0", ifs); end
        checks++; if (gap !== 1'b0) begin errors++; $display("FAIL lw_idle_gap got %b want 0", gap); end
    endtask

    task automatic test_loads();
        logic [3:0]  ops  [0:2];
        logic [31:0] adrs [0:2];
        logic [31:0] exps [0:2];
        int lat; logic [31:0] ld, wm, wd; logic mis, ifs, ce, oe, gap; logic [3:0] be; logic [19:0] sa;
        ops  = '{MEM_LB, MEM_LBU, MEM_LHU};
        adrs = '{32'h107, 32'h107, 32'h106};
        exps = '{32'hFFFFFF88, 32'h00000088, 32'h00008899};
        for (int i = 0; i < 3; i++) begin
            run_mem(ops[i], adrs[i], 32'h0, lat, ld, mis, ifs, ce, wm, oe, wd, be, sa, gap);
            checks++; if (ld !== exps[i] || lat !== WAIT + 1 || mis !== 1'b0) begin errors++;
                $display("FAIL load_fmt op=%0d got %h lat %0d mis %b want %h lat %0d mis 0",
                         ops[i], ld, lat, mis, exps[i], WAIT + 1); end
        end
    endtask

    task automatic test_store_sb();
        int lat; logic [31:0] ld, wm, wd, word; logic mis, ifs, ce, oe, gap; logic [3:0] be; logic [19:0] sa;
        run_mem(MEM_SB, 32'h201, 32'h000000A5, lat, ld, mis, ifs, ce, wm, oe, wd, be, sa, gap);
        ref_store(MEM_SB, 32'h201, 32'h000000A5);
        word = sram_mem[10'h80];
        checks++; if (wd !== 32'hA5A5A5A5) begin errors++; $display("FAIL sb_wdata got %h want a5a5a5a5", wd); end
        checks++; if (be !== 4'b1101) begin errors++; $display("FAIL sb_be_n got %b want 1101", be); end
        checks++; if (wm !== 32'h0000000C) begin errors++; $display("FAIL sb_we_cycles got %h want 0000000c", wm); end
        checks++; if (oe !== 1'b1) begin errors++; $display("FAIL sb_data_oe_done got %b want 1", oe); end
        checks++; if (lat !== WAIT + 1) begin errors++; $display("FAIL sb_latency got %0d want %0d", lat, WAIT + 1); end
        checks++; if (word !== ref_mem[10'h80]) begin errors++; $display("FAIL sb_memory got %h want %h", word, ref_mem[10'h80]); end
    endtask

    task automatic test_misalign();
        int lat; logic [31:0] ld, wm, wd; logic mis, ifs, ce, oe, gap; logic [3:0] be; logic [19:0] sa;
        run_mem(MEM_LH, 32'h103, 32'h0, lat, ld, mis, ifs, ce, wm, oe, wd, be, sa, gap);
        checks++; if (lat !== 1) begin errors++; $display("FAIL mis_latency got %0d want 1", lat); end
        checks++; if (mis !== 1'b1) begin errors++; $display("FAIL mis_flag got %b want 1", mis); end
        checks++; if (ld !== 32'h0) begin errors++; $display("FAIL mis_load_data got %h want 0", ld); end
        checks++; if (ce !== 1'b0) begin errors++; $display("FAIL mis_ce_touched got %b want 0", ce); end
        checks++; if (gap !== 1'b0) begin errors++; $display("FAIL mis_idle_gap got %b want 0", gap); end
    endtask

    task automatic test_reset_abort();
        int pulses; logic we_seen;
        int lat; logic [31:0] ld, wm, wd; logic mis, ifs, ce, oe, gap; logic [3:0] be; logic [19:0] sa;
        pulses = 0;
        bus.mem_ramOp = MEM_SW; bus.mem_addr = 32'h00000FF0; bus.mem_storeData = $urandom;
        @(negedge clk);
        if (bus.mem_success) pulses++;
        @(negedge clk);
        if (bus.mem_success) pulses++;
        we_seen = !bus.sram_we_n;
        rst = 1'b1;
        bus.mem_ramOp = MEM_NOP;
        @(negedge clk);
        if (bus.mem_success || bus.if_success) pulses++;
        checks++; if (we_seen !== 1'b1) begin errors++; $display("FAIL abort_we_cycle2 got %b want 1", we_seen); end
        checks++; if ({bus.sram_ce_n, bus.sram_we_n, bus.sram_data_oe} !== 3'b110) begin errors++;
            $display("FAIL abort_strobes got %b want 110", {bus.sram_ce_n, bus.sram_we_n, bus.sram_data_oe}); end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus.mem_success || bus.if_success) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_success_pulses got %0d want 0", pulses); end
        run_mem(MEM_LW, 32'h104, 32'h0, lat, ld, mis, ifs, ce, wm, oe, wd, be, sa, gap);
        checks++; if (lat !== WAIT + 1 || ld !== ref_load(MEM_LW, 32'h104)) begin errors++;
            $display("FAIL abort_followup_lw got %h lat %0d want %h lat %0d", ld, lat, ref_load(MEM_LW, 32'h104), WAIT + 1); end
    endtask

    // Both requesters held from reset: data, fetch, data, one IDLE between each.
    task automatic test_arbitration();
        int m1, m2, f1, overlap;
        logic [31:0] md1, md2, fd;
        m1 = -1; m2 = -1; f1 = -1; overlap = 0; md1 = '0; md2 = '0; fd = '0;
        @(negedge clk);
        rst = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 32'h104;
        bus.mem_ramOp = MEM_LW; bus.mem_addr = 32'h10C;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (bus.mem_success && bus.if_success) overlap++;
            if (bus.mem_success) begin
                if (m1 < 0) begin m1 = c; md1 = bus.mem_load_data; end
                else if (m2 < 0) begin m2 = c; md2 = bus.mem_load_data; end
                else overlap++;
            end
            if (bus.if_success) begin
                if (f1 < 0) begin f1 = c; fd = bus.if_data; end
                else overlap++;
            end
        end
        checks++; if (m1 !== WAIT + 1) begin errors++; $display("FAIL arb_first_data got %0d want %0d", m1, WAIT + 1); end
        checks++; if (f1 !== 2 * WAIT + 3) begin errors++; $display("FAIL arb_fetch got %0d want %0d", f1, 2 * WAIT + 3); end
        checks++; if (m2 !== 3 * WAIT + 5) begin errors++; $display("FAIL arb_second_data got %0d want %0d", m2, 3 * WAIT + 5); end
        checks++; if (overlap !== 0) begin errors++; $display("FAIL arb_extra_pulses got %0d want 0", overlap); end
        checks++; if (fd !== ref_mem[10'h41]) begin errors++; $display("FAIL arb_if_data got %h want %h", fd, ref_mem[10'h41]); end
        checks++; if (md1 !== ref_load(MEM_LW, 32'h10C) || md2 !== ref_load(MEM_LW, 32'h10C)) begin errors++;
            $display("FAIL arb_mem_data got %h/%h want %h", md1, md2, ref_load(MEM_LW, 32'h10C)); end
        do_reset();
    endtask

    task automatic test_random();
        logic [3:0]  ops [0:7];
        logic [3:0]  op;
        logic [31:0] addr, data, exp_ld;
        logic        exp_mis;
        int          kind, exp_lat;
        int lat; logic [31:0] ld, wm, wd; logic mis, ifs, ce, oe, gap; logic [3:0] be; logic [19:0] sa;
        ops = '{MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW};
        for (int n = 0; n < 80; n++) begin
            kind = $urandom_range(0, 8);
            data = $urandom;
            if (kind == 8) begin
                addr = 32'($urandom_range(0, 255)) << 2;
                run_if(addr, lat, ld, mis, gap);
                checks++; if (lat !== WAIT + 1 || ld !== ref_mem[addr[11:2]] || mis !== 1'b0 || gap !== 1'b0) begin
                    errors++; $display("FAIL rand_fetch n=%0d addr=%h got %h lat %0d mem %b gap %b want %h lat %0d",
                                       n, addr, ld, lat, mis, gap, ref_mem[addr[11:2]], WAIT + 1); end
            end else begin
                op      = ops[kind];
                addr    = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
                exp_mis = ref_misalign(op, addr);
                exp_lat = exp_mis ? 1 : WAIT + 1;
                exp_ld  = (exp_mis || !is_load_op(op)) ? 32'h0 : ref_load(op, addr);
                run_mem(op, addr, data, lat, ld, mis, ifs, ce, wm, oe, wd, be, sa, gap);
                checks++; if (lat !== exp_lat || mis !== exp_mis || ifs !== 1'b0 || gap !== 1'b0) begin
                    errors++; $display("FAIL rand_handshake n=%0d op=%0d addr=%h got lat %0d mis %b if %b gap %b want lat %0d mis %b",
                                       n, op, addr, lat, mis, ifs, gap, exp_lat, exp_mis); end
                if (is_load_op(op)) begin
                    checks++; if (ld !== exp_ld || wm !== 32'h0) begin errors++;
                        $display("FAIL rand_load n=%0d op=%0d addr=%h got %h we %h want %h we 0", n, op, addr, ld, wm, exp_ld); end
                end
                if (exp_mis) begin
                    checks++; if (ce !== 1'b0) begin errors++;
                        $display("FAIL rand_mis_ce n=%0d got %b want 0", n, ce); end
                end else if (!is_load_op(op)) begin
                    checks++; if (wd !== ref_wdata(op, data) || be !== ~ref_lanes(op, addr) || wm !== 32'h0000000C || oe !== 1'b1) begin
                        errors++; $display("FAIL rand_store n=%0d op=%0d addr=%h got wd %h be %b we %h oe %b want wd %h be %b",
                                           n, op, addr, wd, be, wm, oe, ref_wdata(op, data), ~ref_lanes(op, addr)); end
                    ref_store(op, addr, data);
                end
            end
        end
        for (int w = 0; w < 256; w++) begin
            checks++; if (sram_mem[w] !== ref_mem[w]) begin errors++;
                $display("FAIL rand_memory word=%0d got %h want %h", w, sram_mem[w], ref_mem[w]); end
        end
    endtask

    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.mem_ramOp = MEM_NOP; bus.mem_addr = '0; bus.mem_storeData = '0;
        for (int i = 0; i < 1024; i++) begin
            sram_mem[i] = $urandom;
            ref_mem[i]  = sram_mem[i];
        end
        sram_mem[10'h41] = 32'h8899AABB;
        ref_mem[10'h41]  = 32'h8899AABB;
        test_reset();
        test_lw();
        test_loads();
        test_store_sb();
        test_misalign();
        test_reset_abort();
        test_arbitration();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
